hdmi_period_ctrl: RTL

- Sequences the three TMDS encoder channels of the HDMI transmitter. Converts a raw video timing stream (RGB, DE, HSYNC, VSYNC) into per-channel encoder controls: pixel data, data-valid and the two CTL bits.
- In HDMI mode it also inserts the 8-cycle video preamble and flags the 2-cycle video guard band ahead of every active line.
- Sits between the video timing generator and the three encoder instances. The downstream output mux uses `guard_band_o` to substitute guard-band symbols.

---
 rtl/hdmi_pkg.sv | 32 +++
 rtl/hdmi_period_ctrl_sig_delay.sv | 30 +++
 rtl/hdmi_period_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI transmitter period sequencing.
package hdmi_pkg;

  // Data-island-free video period states of one line
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_GUARD    = 2'd2,
    ST_ACTIVE   = 2'd3
  } period_state_t;

  // CTL bit patterns ordered {CTL0, CTL1, CTL2, CTL3}
  localparam logic [3:0] CTL_IDLE    = 4'b0000;
  localparam logic [3:0] CTL_VID_PRE = 4'b1000;

  // Default period lengths in pixel clocks
  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GB_LEN       = 2;

  localparam int unsigned PX_W = 24;

  // One raw video timing sample as it travels down the look-ahead line
  typedef struct packed {
    logic [PX_W-1:0] px;
    logic            de;
    logic            hsync;
    logic            vsync;
  } vid_sample_t;

  localparam int unsigned SAMPLE_W = $bits(vid_sample_t);

endpackage

// File: rtl/hdmi_period_ctrl_sig_delay.sv
// Fixed-depth register shift line with asynchronous active-low clear.
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; reset empties the whole line
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_period_ctrl.sv
// Turns a raw video timing stream into TMDS encoder controls, inserting the
// HDMI video preamble and guard band ahead of each active line.
module hdmi_period_ctrl #(
  parameter int unsigned PREAMBLE_LEN = hdmi_pkg::PREAMBLE_LEN,
  parameter int unsigned GB_LEN       = hdmi_pkg::GB_LEN
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [hdmi_pkg::PX_W-1:0] px_data_i,
  input  logic                      de_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      hdmi_mode_i,
  output logic [2:0][7:0]           ch_data_o,
  output logic [2:0]                ch_val_o,
  output logic [2:0]                ch_ctl0_o,
  output logic [2:0]                ch_ctl1_o,
  output logic                      guard_band_o,
  output logic                      short_blank_o
);

  import hdmi_pkg::*;

  localparam int unsigned DLY     = PREAMBLE_LEN + GB_LEN;
  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > GB_LEN) ? PREAMBLE_LEN : GB_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GB_LAST  = CNT_W'(GB_LEN - 1);

  vid_sample_t          in_s;
  vid_sample_t          dly_s;
  logic [SAMPLE_W-1:0]  dly_bits;

  period_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 de_q;

  logic                 de_rise;
  logic                 line_free;
  logic                 short_d;
  logic [3:0]           ctl_d;
  logic                 gb_d;
  logic [2:0]           val_d;
  logic [2:0][7:0]      data_d;

  assign in_s  = {px_data_i, de_i, hsync_i, vsync_i};
  assign dly_s = vid_sample_t'(dly_bits);

  // Look-ahead line: the FSM sees a DE rise DLY clocks before its pixels
  sig_delay #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DLY)
  ) u_sig_delay (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (in_s),
    .q_o     (dly_bits)
  );

  // State, counter, edge detector and registered encoder controls
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      de_q          <= 1'b0;
      ch_data_o     <= '0;
      ch_val_o      <= '0;
      ch_ctl0_o     <= '0;
      ch_ctl1_o     <= '0;
      guard_band_o  <= 1'b0;
      short_blank_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      de_q          <= de_i;
      ch_data_o     <= data_d;
      ch_val_o      <= val_d;
      ch_ctl0_o     <= {ctl_d[1], ctl_d[3], dly_s.hsync};
      ch_ctl1_o     <= {ctl_d[0], ctl_d[2], dly_s.vsync};
      guard_band_o  <= gb_d;
      short_blank_o <= short_d;
    end
  end

  // Period sequencing and next output values (decoded from the next state)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    short_d   = short_blank_o;
    ctl_d     = CTL_IDLE;
    gb_d      = 1'b0;
    val_d     = 3'b000;
    data_d    = '0;
    de_rise   = de_i & ~de_q;
    // The output side is idle, or leaves ACTIVE on this very clock
    line_free = ~dly_s.de & ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));

    case (state_q)
      ST_IDLE: begin
        if (dly_s.de) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GUARD: begin
        if (cnt_q == GB_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!dly_s.de) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Mode is only looked at on the DE rise; a busy pipe means short blanking
    if (de_rise) begin
      if (!line_free) begin
        short_d = 1'b1;
      end else if (hdmi_mode_i) begin
        state_d = ST_PREAMBLE;
        cnt_d   = '0;
      end
    end

    if (state_d == ST_PREAMBLE) begin
      ctl_d = CTL_VID_PRE;
    end
    gb_d = (state_d == ST_GUARD);
    if (dly_s.de && !gb_d) begin
      val_d  = 3'b111;
      data_d = dly_s.px;
    end
  end

endmodule
